// File: rtl/gf180mcu_dlyline_cal_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// gf180mcu_dlyline_cal_ctrl : tap-sweep calibration sequencer for a dlya delay
// line; optional LOCKED-state tracking enabled by macro DLYCAL_TRACK_EN. Rev 1.0
// ---------------------------------------------------------------------------
module gf180mcu_dlyline_cal_ctrl #(
  parameter int TAP_W        = 4,
  parameter int SETTLE_CYC   = 4,
  parameter int TRACK_PERIOD = 64
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             START,
  input  logic             PD,
  output logic [TAP_W-1:0] TAP,
  output logic             BUSY,
  output logic             DONE,
  output logic             LOCK,
  output logic             FAIL
);

  localparam logic [TAP_W-1:0] TAP_MAX     = '1;
  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 2 || SETTLE_CYC > 255 || TRACK_PERIOD < SETTLE_CYC + 1) begin : g_param_check
    $error("gf180mcu_dlyline_cal_ctrl: illegal SETTLE_CYC/TRACK_PERIOD");
  end

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_LOCKED = 3'd3,
    ST_FAILED = 3'd4
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       pd_meta;
  logic       pd_s;

`ifdef DLYCAL_TRACK_EN
  localparam int             TRK_W      = $clog2(TRACK_PERIOD);
  localparam logic [TRK_W-1:0] TRACK_LAST = TRK_W'(TRACK_PERIOD - 1);
  logic [TRK_W-1:0] track_cnt;
`endif

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state   <= ST_IDLE;
      TAP     <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      LOCK    <= 1'b0;
      FAIL    <= 1'b0;
      cnt     <= '0;
      pd_meta <= 1'b0;
      pd_s    <= 1'b0;
`ifdef DLYCAL_TRACK_EN
      track_cnt <= '0;
`endif
    end else begin
      pd_meta <= PD;
      pd_s    <= pd_meta;
      DONE    <= 1'b0;
      unique case (state)
        ST_IDLE, ST_LOCKED, ST_FAILED: begin
          if (START) begin
            TAP   <= '0;
            cnt   <= '0;
            BUSY  <= 1'b1;
            LOCK  <= 1'b0;
            FAIL  <= 1'b0;
            state <= ST_SETTLE;
          end
`ifdef DLYCAL_TRACK_EN
          // Slow dither around the edge; saturates at both ends of the line.
          else if (state == ST_LOCKED) begin
            if (track_cnt == TRACK_LAST) begin
              track_cnt <= '0;
              if (pd_s) begin
                if (TAP != '0) TAP <= TAP - 1'b1;
              end else if (TAP != TAP_MAX) begin
                TAP <= TAP + 1'b1;
              end
            end else begin
              track_cnt <= track_cnt + 1'b1;
            end
          end
`endif
        end
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == SETTLE_LAST) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (pd_s) begin
            LOCK  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_LOCKED;
`ifdef DLYCAL_TRACK_EN
            track_cnt <= '0;
`endif
          end else if (TAP == TAP_MAX) begin
            FAIL  <= 1'b1;
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= ST_FAILED;
          end else begin
            // Only tap change during a sweep: keeps the mux select glitch-free.
            TAP   <= TAP + 1'b1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_dlyline_cal_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_gf180mcu_dlyline_cal_ctrl : directed bench for the delay-line calibrator
// with a threshold phase-detector model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_gf180mcu_dlyline_cal_ctrl;

  logic       CLK;
  logic       RN;
  logic       START;
  logic       PD;
  logic [3:0] TAP;
  logic       BUSY;
  logic       DONE;
  logic       LOCK;
  logic       FAIL;

  logic [4:0] thr;
  int checks   = 0;
  int failures = 0;

  gf180mcu_dlyline_cal_ctrl dut (
    .CLK   (CLK),
    .RN    (RN),
    .START (START),
    .PD    (PD),
    .TAP   (TAP),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .LOCK  (LOCK),
    .FAIL  (FAIL)
  );

  // Detector reports "late" once the selected tap reaches the threshold.
  assign PD = ({1'b0, TAP} >= thr);

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse START, optionally re-pulse it at cycle ign_at, and expect one DONE
  // at cycle exp_cyc with the tap ramping one step every 5 cycles before it.
  task automatic sweep(input string tag, input int ign_at, input int exp_cyc,
                       input int exp_tap, input logic exp_lock);
    int   done_cyc;
    int   ndone;
    int   ramp_err;
    logic busy_at_done;
    logic [3:0] tap_at_done;
    logic lock_at_done;
    logic fail_at_done;
    done_cyc = -1; ndone = 0; ramp_err = 0;
    busy_at_done = 1'bx; tap_at_done = 'x; lock_at_done = 1'bx; fail_at_done = 1'bx;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    check({tag, "_start_busy"}, BUSY, 1);
    check({tag, "_start_tap"},  TAP,  0);
    check({tag, "_start_lock"}, LOCK, 0);
    check({tag, "_start_fail"}, FAIL, 0);
    for (int cyc = 1; cyc <= exp_cyc + 10; cyc++) begin
      START = (cyc == ign_at);
      @(negedge CLK);
      if (cyc < exp_cyc && (TAP !== 4'(cyc / 5) || BUSY !== 1'b1)) ramp_err++;
      if (DONE) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc; tap_at_done = TAP; lock_at_done = LOCK;
          fail_at_done = FAIL; busy_at_done = BUSY;
        end
      end
    end
    START = 1'b0;
    check({tag, "_done_cycle"}, done_cyc, exp_cyc);
    check({tag, "_done_count"}, ndone, 1);
    check({tag, "_ramp"},       ramp_err, 0);
    check({tag, "_tap"},        tap_at_done, exp_tap);
    check({tag, "_lock"},       lock_at_done, exp_lock);
    check({tag, "_fail"},       fail_at_done, !exp_lock);
    check({tag, "_busy"},       busy_at_done, 0);
    check({tag, "_hold_tap"},   TAP, exp_tap);
    check({tag, "_hold_lock"},  LOCK, exp_lock);
  endtask

  initial begin
    int ndone;
    RN = 1'b0; START = 1'b0; thr = 5'd16;
    repeat (3) @(negedge CLK);
    check("rst_tap",  TAP,  0);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_lock", LOCK, 0);
    check("rst_fail", FAIL, 0);
    RN = 1'b1;
    repeat (2) @(negedge CLK);
    check("idle_busy", BUSY, 0);

    // No tap ever late: full sweep to the top then FAIL.
    sweep("fail", 0, 80, 15, 1'b0);

    // Lock at tap 3, started from FAILED.
    thr = 5'd3;
    sweep("lock3", 0, 20, 3, 1'b1);

    // Restart from LOCKED with a stray START mid-sweep.
    sweep("ignore", 7, 20, 3, 1'b1);

    // Threshold moves: restart clears LOCK on the start edge and relocks.
    thr = 5'd5;
    sweep("relock5", 0, 30, 5, 1'b1);

    // Asynchronous abort at cycle 12 of a sweep.
    thr = 5'd3;
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat (12) @(negedge CLK);
    check("abort_pre_busy", BUSY, 1);
    check("abort_pre_tap",  TAP,  2);
    RN = 1'b0;
    #1;
    check("abort_tap",  TAP,  0);
    check("abort_busy", BUSY, 0);
    check("abort_lock", LOCK, 0);
    @(negedge CLK); RN = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) ndone++;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle_tap", TAP, 0);

    sweep("post_abort", 0, 20, 3, 1'b1);

    repeat (5) @(negedge CLK);
    check("locked_static_tap", TAP, 3);
    check("locked_busy", BUSY, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gf180mcu_dlyline_cal_ctrl.md
Name: gf180mcu_dlyline_cal_ctrl

Overview:
Calibration sequencer for a tapped delay line built from dlya delay cells plus an external tap mux and phase detector. On request, it sweeps the tap select upward from 0 and waits for each tap to settle. It samples the phase-detector output and locks on the first tap where the detector reports that the delayed edge lags the reference. It sits beside the delay line in the analog/mixed-signal wrapper and presents a simple start/done handshake to the digital controller.

Parameters:
TAP_W, 4, tap-select width; the line has 2**TAP_W taps, TAP_MAX = 2**TAP_W-1
SETTLE_CYC, 4, CLK cycles held after each tap change before sampling; legal range 2..255 (covers the 2-flop synchronizer)
TRACK_PERIOD, 64, CLK cycles between tracking samples in LOCKED; used only with DLYCAL_TRACK_EN; legal range >= SETTLE_CYC+1

Ports:
CLK  input  1  clock; all state updates on the rising edge
RN  input  1  asynchronous active-low reset
START  input  1  calibration request; sampled high for one cycle
PD  input  1  phase-detector output; asynchronous to CLK; 1 = delayed edge late
TAP  output  TAP_W  tap select driven to the delay-line mux
BUSY  output  1  high while a sweep is in progress
DONE  output  1  one-cycle pulse when a sweep ends (lock or fail)
LOCK  output  1  level; a lock tap was found and is held on TAP
FAIL  output  1  level; no tap produced PD=1

Behaviour:
- Reset is asynchronous and active-low (RN low): state=IDLE, TAP=0, BUSY=0, DONE=0, LOCK=0, FAIL=0, settle counter=0, synchronizer flops=0.
- PD passes through a 2-flop synchronizer. All decisions use the synchronized value pd_s.
- State IDLE: START=1 -> TAP=0, cnt=0, BUSY=1, clear LOCK/FAIL, go SETTLE.
- State SETTLE: cnt increments each cycle. When cnt==SETTLE_CYC-1, go SAMPLE.
- State SAMPLE (one cycle):
  - pd_s=1 -> go LOCKED; TAP held; LOCK=1; BUSY=0; DONE=1 for exactly one cycle.
  - pd_s=0 and TAP==TAP_MAX -> go FAILED; TAP held at TAP_MAX; FAIL=1; BUSY=0; DONE pulse.
  - pd_s=0 and TAP<TAP_MAX -> TAP+1, cnt=0, go SETTLE. TAP never wraps.
- Timing: each tap costs SETTLE_CYC+1 cycles. For a lock at tap k, DONE is high in the cycle starting (k+1)*(SETTLE_CYC+1) edges after the edge that sampled START. With defaults, a lock at tap 3 gives DONE 20 cycles after START.
- State LOCKED / FAILED: outputs hold. START=1 restarts exactly as from IDLE, with LOCK/FAIL cleared in the same edge.
- START while BUSY=1 is ignored. There is no queueing.
- TAP changes only on the edge leaving SAMPLE (or on restart/reset), so it is glitch-free for the mux.
- DONE and LOCK/FAIL assert on the same edge. LOCK and FAIL are never both 1.
- RN asserted mid-sweep: immediate return to reset values. No DONE is produced for the aborted sweep.

Optional Feature:
DLYCAL_TRACK_EN
- Defined: in LOCKED, a free-running counter samples pd_s every TRACK_PERIOD cycles.
  - pd_s=0 -> TAP+1, saturating at TAP_MAX.
  - pd_s=1 -> TAP-1, saturating at 0.
  - LOCK stays 1, BUSY stays 0, and no DONE pulse is produced.
  - The counter resets on entry to LOCKED and on every tap step.
- Not defined: LOCKED is static, and the TRACK_PERIOD counter and logic are absent.

Test Plan:
- Reset, then PD held 0, START pulse (defaults) -> TAP steps 0..15, one step every 5 cycles. DONE pulses once at cycle 80; FAIL=1; TAP=15; LOCK=0.
- PD tied to a model that returns 1 when TAP>=3, START pulse -> DONE at cycle 20; LOCK=1; TAP=3; BUSY falls with DONE.
- START re-pulsed during the sweep at cycle 7 -> ignored; same DONE timing and TAP result as the previous case.
- RN pulsed low at cycle 12 of a sweep -> TAP=0, BUSY=0, no DONE; a later START produces a full, correct sweep.
- From LOCKED at TAP=3, the model threshold moves to 5, START pulse -> LOCK cleared on the same edge, relock at TAP=5, DONE at cycle 30.
- With DLYCAL_TRACK_EN: locked at 3, threshold moves to 4 -> TAP becomes 4 after one TRACK_PERIOD, then dithers 3/4 each period. LOCK remains 1 and DONE stays 0.
